// File: rtl/siicpu_soc.sv
// rtl/siicpu_soc.sv - single-cycle RV32I core with a 256-word data TCM and an mtime counter
module siicpu_soc #(
  parameter int PC_WIDTH   = 32,
  parameter int WORD_WIDTH = 32,
  parameter int DTCM_AW    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_en,
  input  logic                  io_rtcToggle,
  output logic                  rd_insn_en,
  output logic [PC_WIDTH-1:0]   pc,
  input  logic [WORD_WIDTH-1:0] insn
);
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_IMM    = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  logic [WORD_WIDTH-1:0] rf_q   [32];
  logic [WORD_WIDTH-1:0] dtcm_q [2**DTCM_AW];
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [63:0]           mtime_q, mtime_d;
  logic                  rtc_q, rtc_d;

  logic [6:0]            opcode;
  logic [4:0]            rd, rs1, rs2;
  logic [2:0]            f3;
  logic [WORD_WIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [WORD_WIDTH-1:0] rs1_v, rs2_v, pc_w, alu_b, alu_res, pc_next, wb_data;
  logic [DTCM_AW-1:0]    ls_idx;
  logic                  br_taken, wb_en, st_en;

  assign rd_insn_en = cpu_en & rst_n;
  assign pc         = pc_q;

  assign opcode = insn[6:0];
  assign rd     = insn[11:7];
  assign f3     = insn[14:12];
  assign rs1    = insn[19:15];
  assign rs2    = insn[24:20];
  assign imm_i  = {{20{insn[31]}}, insn[31:20]};
  assign imm_s  = {{20{insn[31]}}, insn[31:25], insn[11:7]};
  assign imm_b  = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
  assign imm_u  = {insn[31:12], 12'h000};
  assign imm_j  = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};

  assign rs1_v  = (rs1 == 5'd0) ? '0 : rf_q[rs1];
  assign rs2_v  = (rs2 == 5'd0) ? '0 : rf_q[rs2];
  assign pc_w   = WORD_WIDTH'(pc_q);
  // Upper address bits and the byte offset fall away here, so the DTCM aliases across memory.
  assign ls_idx = DTCM_AW'((rs1_v + ((opcode == OPC_STORE) ? imm_s : imm_i)) >> 2);

  always_comb begin
    alu_b   = (opcode == OPC_OP) ? rs2_v : imm_i;
    alu_res = '0;
    case (f3)
      3'd0: alu_res = ((opcode == OPC_OP) && insn[30]) ? rs1_v - alu_b : rs1_v + alu_b;
      3'd1: alu_res = rs1_v << alu_b[4:0];
      3'd2: alu_res = {31'd0, $signed(rs1_v) < $signed(alu_b)};
      3'd3: alu_res = {31'd0, rs1_v < alu_b};
      3'd4: alu_res = rs1_v ^ alu_b;
      3'd5: alu_res = insn[30] ? WORD_WIDTH'($signed(rs1_v) >>> alu_b[4:0]) : rs1_v >> alu_b[4:0];
      3'd6: alu_res = rs1_v | alu_b;
      default: alu_res = rs1_v & alu_b;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (f3)
      3'd0: br_taken = (rs1_v == rs2_v);
      3'd1: br_taken = (rs1_v != rs2_v);
      3'd4: br_taken = ($signed(rs1_v) < $signed(rs2_v));
      3'd5: br_taken = ($signed(rs1_v) >= $signed(rs2_v));
      3'd6: br_taken = (rs1_v < rs2_v);
      3'd7: br_taken = (rs1_v >= rs2_v);
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    wb_en   = 1'b0;
    wb_data = '0;
    st_en   = 1'b0;
    pc_next = pc_w + 32'd4;
    case (opcode)
      OPC_LUI:    begin wb_en = 1'b1; wb_data = imm_u; end
      OPC_AUIPC:  begin wb_en = 1'b1; wb_data = pc_w + imm_u; end
      OPC_JAL:    begin wb_en = 1'b1; wb_data = pc_w + 32'd4; pc_next = pc_w + imm_j; end
      OPC_JALR:   begin wb_en = 1'b1; wb_data = pc_w + 32'd4; pc_next = (rs1_v + imm_i) & ~32'd1; end
      OPC_BRANCH: if (br_taken) pc_next = pc_w + imm_b;
      OPC_LOAD:   if (f3 == 3'd2) begin wb_en = 1'b1; wb_data = dtcm_q[ls_idx]; end
      OPC_STORE:  st_en = (f3 == 3'd2);
      OPC_IMM, OPC_OP: begin wb_en = 1'b1; wb_data = alu_res; end
      OPC_SYSTEM: begin
        if (f3 == 3'd2 && rs1 == 5'd0) begin
          wb_en = 1'b1;
          case (insn[31:20])
            12'hC01: wb_data = mtime_q[31:0];
            12'hC81: wb_data = mtime_q[63:32];
            default: wb_data = '0;
          endcase
        end
      end
      default: ;
    endcase
    wb_en   = wb_en & rd_insn_en & (rd != 5'd0);
    st_en   = st_en & rd_insn_en;
    pc_d    = rd_insn_en ? PC_WIDTH'(pc_next & ~32'd3) : pc_q;
    rtc_d   = io_rtcToggle;
    mtime_d = mtime_q + {63'd0, io_rtcToggle & ~rtc_q};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= '0;
      mtime_q <= '0;
      rtc_q   <= 1'b0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      pc_q    <= pc_d;
      mtime_q <= mtime_d;
      rtc_q   <= rtc_d;
      if (wb_en) rf_q[rd] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (st_en) dtcm_q[ls_idx] <= rs2_v;
  end
endmodule

// File: tb/tb_siicpu_soc.sv
// tb/tb_siicpu_soc.sv - directed and random instruction stream against an instruction-level model
module tb_siicpu_soc;
  typedef enum int {
    O_ADD, O_SUB, O_SLL, O_SLT, O_SLTU, O_XOR, O_SRL, O_SRA, O_OR, O_AND,
    O_ADDI, O_SLTI, O_SLTIU, O_XORI, O_ORI, O_ANDI, O_SLLI, O_SRLI, O_SRAI,
    O_LUI, O_AUIPC, O_JAL, O_JALR, O_BEQ, O_BNE, O_BLT, O_BGE, O_BLTU, O_BGEU,
    O_LW, O_SW, O_RDTIME, O_RDTIMEH, O_RDOTHER, O_NOP
  } op_e;

  logic        clk = 1'b0;
  logic        rst_n, cpu_en, io_rtcToggle, rd_insn_en;
  logic [31:0] pc, insn, insn_drv;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_x [32];
  logic [31:0] m_dmem [256];
  bit          dvalid [256];
  logic [31:0] m_pc;
  logic [63:0] m_mtime;
  logic        m_rtc;

  always #5 clk = ~clk;
  assign insn = rd_insn_en ? insn_drv : 32'h0;

  siicpu_soc dut (
    .clk(clk), .rst_n(rst_n), .cpu_en(cpu_en), .io_rtcToggle(io_rtcToggle),
    .rd_insn_en(rd_insn_en), .pc(pc), .insn(insn)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, rs1, rs2);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] itype(input logic [31:0] imm, input logic [2:0] f3,
                                        input logic [4:0] rd, rs1, input logic [6:0] opc);
    return {imm[11:0], rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] btype(input logic [31:0] imm, input logic [2:0] f3,
                                        input logic [4:0] rs1, rs2);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc(input op_e op, input logic [4:0] rd, rs1, rs2,
                                      input logic [31:0] imm);
    case (op)
      O_ADD:     return rtype(7'h00, 3'd0, rd, rs1, rs2);
      O_SUB:     return rtype(7'h20, 3'd0, rd, rs1, rs2);
      O_SLL:     return rtype(7'h00, 3'd1, rd, rs1, rs2);
      O_SLT:     return rtype(7'h00, 3'd2, rd, rs1, rs2);
      O_SLTU:    return rtype(7'h00, 3'd3, rd, rs1, rs2);
      O_XOR:     return rtype(7'h00, 3'd4, rd, rs1, rs2);
      O_SRL:     return rtype(7'h00, 3'd5, rd, rs1, rs2);
      O_SRA:     return rtype(7'h20, 3'd5, rd, rs1, rs2);
      O_OR:      return rtype(7'h00, 3'd6, rd, rs1, rs2);
      O_AND:     return rtype(7'h00, 3'd7, rd, rs1, rs2);
      O_ADDI:    return itype(imm, 3'd0, rd, rs1, 7'h13);
      O_SLTI:    return itype(imm, 3'd2, rd, rs1, 7'h13);
      O_SLTIU:   return itype(imm, 3'd3, rd, rs1, 7'h13);
      O_XORI:    return itype(imm, 3'd4, rd, rs1, 7'h13);
      O_ORI:     return itype(imm, 3'd6, rd, rs1, 7'h13);
      O_ANDI:    return itype(imm, 3'd7, rd, rs1, 7'h13);
      O_SLLI:    return itype({27'd0, imm[4:0]}, 3'd1, rd, rs1, 7'h13);
      O_SRLI:    return itype({27'd0, imm[4:0]}, 3'd5, rd, rs1, 7'h13);
      O_SRAI:    return itype({20'd0, 7'h20, imm[4:0]}, 3'd5, rd, rs1, 7'h13);
      O_LUI:     return {imm[19:0], rd, 7'h37};
      O_AUIPC:   return {imm[19:0], rd, 7'h17};
      O_JAL:     return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
      O_JALR:    return itype(imm, 3'd0, rd, rs1, 7'h67);
      O_BEQ:     return btype(imm, 3'd0, rs1, rs2);
      O_BNE:     return btype(imm, 3'd1, rs1, rs2);
      O_BLT:     return btype(imm, 3'd4, rs1, rs2);
      O_BGE:     return btype(imm, 3'd5, rs1, rs2);
      O_BLTU:    return btype(imm, 3'd6, rs1, rs2);
      O_BGEU:    return btype(imm, 3'd7, rs1, rs2);
      O_LW:      return itype(imm, 3'd2, rd, rs1, 7'h03);
      O_SW:      return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'h23};
      O_RDTIME:  return itype(32'hC01, 3'd2, rd, 5'd0, 7'h73);
      O_RDTIMEH: return itype(32'hC81, 3'd2, rd, 5'd0, 7'h73);
      O_RDOTHER: return itype(32'hC00, 3'd2, rd, 5'd0, 7'h73);
      default: begin
        case (imm[1:0])
          2'd0:    return 32'h0000_0073;
          2'd1:    return 32'h0000_000f;
          2'd2:    return itype(32'h0, 3'd0, rd, rs1, 7'h03);
          default: return {7'h00, rs2, rs1, 3'd0, 5'd0, 7'h23};
        endcase
      end
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_x[i] = 32'h0;
    m_pc = 32'h0;
    m_mtime = 64'h0;
    m_rtc = 1'b0;
  endtask

  task automatic model_exec(input op_e op, input int rd, rs1, rs2, input logic [31:0] imm);
    logic [31:0] a, b, r, npc, ad;
    logic w;
    a = m_x[rs1]; b = m_x[rs2]; r = 32'h0; w = 1'b1; npc = m_pc + 32'd4;
    ad = a + imm;
    case (op)
      O_ADD:   r = a + b;
      O_SUB:   r = a - b;
      O_SLL:   r = a << b[4:0];
      O_SLT:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      O_SLTU:  r = (a < b) ? 32'd1 : 32'd0;
      O_XOR:   r = a ^ b;
      O_SRL:   r = a >> b[4:0];
      O_SRA:   r = $signed(a) >>> b[4:0];
      O_OR:    r = a | b;
      O_AND:   r = a & b;
      O_ADDI:  r = a + imm;
      O_SLTI:  r = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
      O_SLTIU: r = (a < imm) ? 32'd1 : 32'd0;
      O_XORI:  r = a ^ imm;
      O_ORI:   r = a | imm;
      O_ANDI:  r = a & imm;
      O_SLLI:  r = a << imm[4:0];
      O_SRLI:  r = a >> imm[4:0];
      O_SRAI:  r = $signed(a) >>> imm[4:0];
      O_LUI:   r = imm << 12;
      O_AUIPC: r = m_pc + (imm << 12);
      O_JAL:   begin r = m_pc + 32'd4; npc = m_pc + imm; end
      O_JALR:  begin r = m_pc + 32'd4; npc = (a + imm) & ~32'd1; end
      O_BEQ:   begin w = 1'b0; if (a == b) npc = m_pc + imm; end
      O_BNE:   begin w = 1'b0; if (a != b) npc = m_pc + imm; end
      O_BLT:   begin w = 1'b0; if ($signed(a) < $signed(b)) npc = m_pc + imm; end
      O_BGE:   begin w = 1'b0; if ($signed(a) >= $signed(b)) npc = m_pc + imm; end
      O_BLTU:  begin w = 1'b0; if (a < b) npc = m_pc + imm; end
      O_BGEU:  begin w = 1'b0; if (a >= b) npc = m_pc + imm; end
      O_LW:    r = m_dmem[ad[9:2]];
      O_SW:    begin w = 1'b0; m_dmem[ad[9:2]] = b; end
      O_RDTIME:  r = m_mtime[31:0];
      O_RDTIMEH: r = m_mtime[63:32];
      O_RDOTHER: r = 32'h0;
      default: w = 1'b0;
    endcase
    if (w && rd != 0) m_x[rd] = r;
    m_pc = npc & ~32'd3;
  endtask

  // Called just after a falling edge; leaves the bench on the next falling edge.
  task automatic step(input op_e op, input int rd, rs1, rs2, input logic [31:0] imm,
                      input logic tog, input logic en, input logic rstn);
    insn_drv = enc(op, 5'(rd), 5'(rs1), 5'(rs2), imm);
    io_rtcToggle = tog;
    cpu_en = en;
    rst_n = rstn;
    if (!rstn) model_reset();
    else begin
      if (en) model_exec(op, rd, rs1, rs2, imm);
      if (tog && !m_rtc) m_mtime = m_mtime + 64'd1;
      m_rtc = tog;
    end
    @(posedge clk);
    #1;
    chk("pc", pc, m_pc);
    chk("rd_insn_en", {31'd0, rd_insn_en}, {31'd0, en & rstn});
    chk("xreg", dut.rf_q[rd], m_x[rd]);
    @(negedge clk);
  endtask

  task automatic ex(input op_e op, input int rd, rs1, rs2, input logic [31:0] imm);
    step(op, rd, rs1, rs2, imm, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic tk(input logic tog);
    step(O_NOP, 0, 0, 0, 32'h0, tog, 1'b1, 1'b1);
  endtask

  function automatic logic [31:0] rand_imm(input op_e op);
    logic [31:0] v;
    v = $urandom;
    case (op)
      O_SLL, O_SLLI, O_SRLI, O_SRAI: return {27'd0, v[4:0]};
      O_LUI, O_AUIPC:                return {12'd0, v[19:0]};
      O_JAL:                         return {{11{v[20]}}, v[20:1], 1'b0};
      O_BEQ, O_BNE, O_BLT, O_BGE, O_BLTU, O_BGEU: return {{19{v[12]}}, v[12:1], 1'b0};
      default:                       return {{20{v[11]}}, v[11:0]};
    endcase
  endfunction

  initial begin
    logic [31:0] p, imm;
    op_e op;
    int idx, rd, rs1, rs2;
    rst_n = 1'b0; cpu_en = 1'b1; io_rtcToggle = 1'b0; insn_drv = 32'h0;
    model_reset();
    for (int i = 0; i < 256; i++) begin m_dmem[i] = 32'h0; dvalid[i] = 1'b0; end

    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc", pc, 32'h0);
    chk("reset_rd_insn_en", {31'd0, rd_insn_en}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; cpu_en = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_pc", pc, 32'h0);
    chk("idle_rd_insn_en", {31'd0, rd_insn_en}, 32'h0);
    @(negedge clk);

    ex(O_ADDI, 1, 0, 0, 32'd5);
    chk("addi_pc", pc, 32'h4);
    ex(O_ADDI, 2, 1, 0, -32'sd3);
    ex(O_ADD, 3, 1, 2, 32'h0);
    chk("add_pc", pc, 32'hC);
    chk("x3", dut.rf_q[3], 32'd7);
    ex(O_SUB, 4, 2, 1, 32'h0);
    chk("x4", dut.rf_q[4], 32'hFFFF_FFFD);

    ex(O_SW, 0, 0, 3, 32'd16);
    ex(O_LW, 5, 0, 0, 32'd16);
    chk("x5", dut.rf_q[5], 32'd7);
    ex(O_SW, 0, 0, 1, 32'h410);
    ex(O_LW, 7, 0, 0, 32'd16);
    chk("alias", dut.rf_q[7], 32'd5);
    dvalid[4] = 1'b1;

    ex(O_JAL, 0, 0, 0, -32'sd16);
    ex(O_BEQ, 0, 0, 0, 32'd8);
    chk("beq_pc", pc, 32'h18);
    ex(O_JAL, 1, 0, 0, -32'sd8);
    chk("jal_pc", pc, 32'h10);
    chk("jal_link", dut.rf_q[1], 32'h1C);
    ex(O_BNE, 0, 0, 0, 32'd8);
    chk("bne_pc", pc, 32'h14);

    repeat (3) begin tk(1'b1); tk(1'b0); end
    ex(O_RDTIME, 6, 0, 0, 32'h0);
    chk("time3", dut.rf_q[6], 32'd3);
    repeat (5) tk(1'b1);
    tk(1'b0);
    ex(O_RDTIME, 8, 0, 0, 32'h0);
    chk("time4", dut.rf_q[8], 32'd4);
    ex(O_RDTIMEH, 9, 0, 0, 32'h0);
    chk("timeh", dut.rf_q[9], 32'd0);
    step(O_RDTIME, 10, 0, 0, 32'h0, 1'b1, 1'b1, 1'b1);
    chk("time_pre_inc", dut.rf_q[10], 32'd4);

    p = m_pc;
    repeat (3) step(O_ADDI, 11, 0, 0, 32'd99, 1'b0, 1'b0, 1'b1);
    chk("stall_pc", pc, p);
    chk("stall_reg", dut.rf_q[11], 32'd0);
    ex(O_ADDI, 11, 0, 0, 32'd99);
    chk("resume_pc", pc, p + 32'd4);
    chk("resume_reg", dut.rf_q[11], 32'd99);

    step(O_ADDI, 12, 0, 0, 32'd1, 1'b0, 1'b1, 1'b0);
    chk("midreset_pc", pc, 32'h0);
    ex(O_LW, 13, 0, 0, 32'd16);
    chk("dtcm_kept", dut.rf_q[13], 32'd5);

    for (int n = 0; n < 400; n++) begin
      op  = op_e'($urandom_range(0, int'(O_NOP)));
      rd  = $urandom_range(0, 31);
      rs1 = $urandom_range(0, 31);
      rs2 = $urandom_range(0, 31);
      imm = rand_imm(op);
      if (op == O_LW || op == O_SW) begin
        idx = $urandom_range(0, 255);
        rs1 = 0;
        imm = 32'(idx * 4 + $urandom_range(0, 1) * 1024);
        if (!dvalid[idx]) op = O_SW;
        if (op == O_SW) dvalid[idx] = 1'b1;
      end
      step(op, rd, rs1, rs2, imm, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) != 0), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
